// File: rtl/store_write_buffer.sv
// Posted-store write buffer between the MEM stage and a single-port data memory, with store-to-load forwarding.
// Latency: a store is captured on the accepting edge; one entry drains per free memory cycle; loads forward combinationally.
// Backpressure: Stall only when a store meets a full buffer; a full buffer always drains that cycle, so Stall lasts one cycle at most.
module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic [ADDR_W-1:0]          CpuAddress,
  input  logic [DATA_W-1:0]          CpuWriteData,
  input  logic                       CpuMemWrite,
  input  logic                       CpuMemRead,
  output logic [DATA_W-1:0]          CpuReadData,
  output logic                       Stall,
  output logic [ADDR_W-1:0]          MemAddress,
  output logic [DATA_W-1:0]          MemWriteData,
  output logic                       MemWrite,
  input  logic [DATA_W-1:0]          MemReadData,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int WA_W  = ADDR_W - 2;

  logic [WA_W-1:0]   entryAddr [DEPTH];
  logic [DATA_W-1:0] entryData [DEPTH];
  logic [DEPTH-1:0]  entryValid;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  fwdIdx;
  logic              full;
  logic              drain;
  logic              accept;
  logic [WA_W-1:0]   cpuWordAddr;

  assign cpuWordAddr = CpuAddress[ADDR_W-1:2];
  assign full        = (Count == CNT_W'(DEPTH));
  assign Empty       = (Count == '0);

  // A store wins over a simultaneous load; a full buffer must drain even with a store waiting
  // so that the stalled store is guaranteed a slot on the following cycle.
  assign accept = CpuMemWrite && !full;
  assign drain  = !Empty && !CpuMemRead && (!CpuMemWrite || full);
  assign Stall  = CpuMemWrite && full;

  // The memory port is shared: loads own the address bus, otherwise it carries the head entry.
  assign MemWrite     = drain;
  assign MemWriteData = entryData[head];
  assign MemAddress   = CpuMemRead ? CpuAddress : {entryAddr[head], 2'b00};

  // Pointer, occupancy and valid-bit bookkeeping; reset discards all pending stores.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      head       <= '0;
      tail       <= '0;
      Count      <= '0;
      entryValid <= '0;
    end else begin
      if (accept) begin
        tail             <= tail + 1'b1;
        entryValid[tail] <= 1'b1;
      end
      if (drain) begin
        head             <= head + 1'b1;
        entryValid[head] <= 1'b0;
      end
      // accept and drain are mutually exclusive, so Count moves by at most one.
      if (accept) begin
        Count <= Count + 1'b1;
      end else if (drain) begin
        Count <= Count - 1'b1;
      end
    end
  end

  // Entry payload written at the tail; cleared on reset so forwarded data is never X.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entryAddr[i] <= '0;
        entryData[i] <= '0;
      end
    end else if (accept) begin
      entryAddr[tail] <= cpuWordAddr;
      entryData[tail] <= CpuWriteData;
    end
  end

  // Youngest-match forwarding: scan from head (oldest) toward tail so the last hit wins.
  always_comb begin
    CpuReadData = MemReadData;
    fwdIdx      = head;
    for (int k = 0; k < DEPTH; k++) begin
      fwdIdx = head + PTR_W'(k);
      if (entryValid[fwdIdx] && (entryAddr[fwdIdx] == cpuWordAddr)) begin
        CpuReadData = entryData[fwdIdx];
      end
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed scenarios plus randomized traffic against a queue-based model.
// Latency: model predicts outputs each cycle from the pending-store queue and a reference memory image.
// Backpressure: a stalled store is held by the driver until it is accepted.
module tb_store_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic [ADDR_W-1:0] CpuAddress = '0;
  logic [DATA_W-1:0] CpuWriteData = '0;
  logic              CpuMemWrite = 1'b0;
  logic              CpuMemRead = 1'b0;
  logic [DATA_W-1:0] CpuReadData;
  logic              Stall;
  logic [ADDR_W-1:0] MemAddress;
  logic [DATA_W-1:0] MemWriteData;
  logic              MemWrite;
  logic [DATA_W-1:0] MemReadData;
  logic [CNT_W-1:0]  Count;
  logic              Empty;

  typedef struct packed {
    logic [ADDR_W-3:0] wa;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic [DATA_W-1:0] mem    [256];
  logic [DATA_W-1:0] refMem [256];
  ent_t              q[$];
  int                total = 0;
  int                bad   = 0;

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .CpuAddress(CpuAddress), .CpuWriteData(CpuWriteData),
    .CpuMemWrite(CpuMemWrite), .CpuMemRead(CpuMemRead),
    .CpuReadData(CpuReadData), .Stall(Stall),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemReadData(MemReadData),
    .Count(Count), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  // Data memory: combinational read.
  assign MemReadData = mem[MemAddress[9:2]];

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check against the model at negedge, then advance model and memory.
  task automatic cycle(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] data, output logic stallExp);
    logic        full, drain, accept;
    logic [31:0] fwd;
    logic        mw;
    logic [7:0]  ma;
    logic [31:0] md;
    CpuMemWrite  = wr;
    CpuMemRead   = rd;
    CpuAddress   = addr;
    CpuWriteData = data;
    @(negedge Clk);
    full     = (q.size() == DEPTH);
    drain    = (q.size() != 0) && !rd && (!wr || full);
    accept   = wr && !full;
    stallExp = wr && full;
    checkValue("count", 64'(Count), 64'(q.size()));
    checkValue("empty", 64'(Empty), 64'(q.size() == 0));
    checkValue("stall", 64'(Stall), 64'(stallExp));
    checkValue("memWrite", 64'(MemWrite), 64'(drain));
    if (drain) begin
      checkValue("drainAddr", 64'(MemAddress), 64'({q[0].wa, 2'b00}));
      checkValue("drainData", 64'(MemWriteData), 64'(q[0].d));
    end
    if (rd) begin
      fwd = refMem[addr[9:2]];
      foreach (q[i]) if (q[i].wa == addr[31:2]) fwd = q[i].d;
      checkValue("loadAddr", 64'(MemAddress), 64'(addr));
      checkValue("loadData", 64'(CpuReadData), 64'(fwd));
    end
    mw = MemWrite;
    ma = MemAddress[9:2];
    md = MemWriteData;
    if (Rst_n) begin
      if (drain) begin
        refMem[q[0].wa[7:0]] = q[0].d;
        void'(q.pop_front());
      end
      if (accept) q.push_back('{addr[31:2], data});
    end
    @(posedge Clk);
    if (mw) mem[ma] = md;
    #1;
  endtask

  task automatic idle(input int n);
    logic st;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, st);
  endtask

  initial begin
    logic        st;
    logic        held;
    logic        wr, rd;
    logic [31:0] addr, data;
    int          r;

    for (int i = 0; i < 256; i++) begin
      mem[i]    = i;
      refMem[i] = i;
    end

    // 1. Reset held for two cycles with random non-conflicting inputs.
    for (int i = 0; i < 2; i++) begin
      r = $urandom_range(0, 2);
      cycle(r == 1, r == 2, {24'h0, 2'($urandom), 4'($urandom), 2'b00}, $urandom, st);
    end
    for (int i = 0; i < 16; i++) checkValue("rstMemWord", 64'(mem[i]), 64'(i));
    Rst_n = 1'b1;

    // 2. Single store then idle.
    cycle(1'b1, 1'b0, 32'h10, 32'hAA, st);
    idle(1);
    checkValue("word4", 64'(mem[4]), 64'h0AA);
    checkValue("cntAfterDrain", 64'(Count), 64'd0);

    // 3. Youngest-match forwarding (0x24 and 0x27 share a word).
    cycle(1'b1, 1'b0, 32'h24, 32'h11, st);
    cycle(1'b1, 1'b0, 32'h27, 32'h22, st);
    cycle(1'b0, 1'b1, 32'h24, 32'h0, st);
    idle(2);
    checkValue("word9", 64'(mem[9]), 64'h022);
    checkValue("emptyAfterFwd", 64'(Empty), 64'd1);

    // 4. Full and wrap-around: fifth store stalls once then is accepted.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'(i * 4), 32'(32'hA0 + i), st);
    checkValue("fifthStall", 64'(st), 64'd1);
    cycle(1'b1, 1'b0, 32'h10, 32'hA4, st);
    checkValue("fifthAccept", 64'(st), 64'd0);
    checkValue("cntWrap", 64'(Count), 64'd4);
    checkValue("word0", 64'(mem[0]), 64'h0A0);

    // 5. Read miss while stores are pending: data from memory, no drain.
    cycle(1'b0, 1'b1, 32'h14, 32'h0, st);
    idle(DEPTH + 1);
    checkValue("word4Final", 64'(mem[4]), 64'h0A4);

    // 6. Asynchronous reset with three pending stores.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'(32'h40 + i * 4), 32'(32'hD0 + i), st);
    #2;
    Rst_n = 1'b0;
    #1;
    checkValue("midRstCount", 64'(Count), 64'd0);
    checkValue("midRstMemWrite", 64'(MemWrite), 64'd0);
    checkValue("midRstEmpty", 64'(Empty), 64'd1);
    q.delete();
    #2;
    idle(2);
    Rst_n = 1'b1;
    idle(DEPTH + 1);
    for (int i = 16; i < 19; i++) checkValue("discarded", 64'(mem[i]), 64'(i));

    // Randomized traffic over a small address window so forwarding hits are frequent.
    held = 1'b0;
    wr = 1'b0; rd = 1'b0; addr = '0; data = '0;
    for (int i = 0; i < 600; i++) begin
      if (!held) begin
        r    = $urandom_range(0, 9);
        wr   = (r < 5);
        rd   = (r >= 5) && (r < 8);
        addr = {24'h0, 2'b00, 4'($urandom), 2'($urandom)};
        data = $urandom;
      end
      cycle(wr, rd, addr, data, st);
      held = st;
    end
    idle(DEPTH + 1);
    for (int i = 0; i < 32; i++) checkValue("finalMem", 64'(mem[i]), 64'(refMem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
